// File: rtl/nv_ramdp_flop_param.sv
// nv_ramdp_flop_param: parametrised single-clock 1R1W flop-array RAM with
// selectable read latency, write-to-read bypass, per-entry valid bits and a
// sleep/wake sequencer with optional retention.
module nv_ramdp_flop_param #(
    parameter int DW       = 16,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int RD_LAT   = 1,
    parameter int BYPASS   = 1,
    parameter int WAKE_CYC = 4
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          re,
    input  logic [AW-1:0] ra,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    output logic          rd_vld,
    output logic [DW-1:0] rd,
    input  logic          sleep_en,
    input  logic          ret_en,
    output logic          ram_ready,
    output logic          err_drop
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [3:0]  WAKE_C  = 4'(WAKE_CYC);

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      wake_cnt;
    logic [3:0]      wake_cnt_nxt;

    logic [DW-1:0]   mem [DEPTH];
    logic [DEPTH-1:0] valid;

    logic            re_acc;
    logic            we_acc;
    logic            ra_ok;
    logic            wa_ok;
    logic            sleep_entry;
    logic [DW-1:0]   rd_data_nxt;

    logic            s1_vld;
    logic [DW-1:0]   s1_data;

    // Access qualification: only ACTIVE accepts, addresses beyond DEPTH are harmless
    always_comb begin
        re_acc      = re & ram_ready;
        we_acc      = we & ram_ready;
        ra_ok       = ({1'b0, ra} < DEPTH_C);
        wa_ok       = ({1'b0, wa} < DEPTH_C);
        sleep_entry = (state == ST_ACTIVE) && sleep_en;
    end

    // Sequencer state and wake counter; reset restarts the wake sequence
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= ST_WAKE;
            wake_cnt <= WAKE_C;
        end else begin
            state    <= state_nxt;
            wake_cnt <= wake_cnt_nxt;
        end
    end

    // Next-state logic; a re-asserted sleep during WAKE returns straight to SLEEP
    always_comb begin
        state_nxt    = state;
        wake_cnt_nxt = wake_cnt;
        case (state)
            ST_ACTIVE: begin
                if (sleep_en) state_nxt = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (!sleep_en) begin
                    state_nxt    = ST_WAKE;
                    wake_cnt_nxt = WAKE_C;
                end
            end
            ST_WAKE: begin
                if (sleep_en) begin
                    state_nxt = ST_SLEEP;
                end else if (wake_cnt <= 4'd1) begin
                    state_nxt = ST_ACTIVE;
                end else begin
                    wake_cnt_nxt = wake_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt    = ST_WAKE;
                wake_cnt_nxt = WAKE_C;
            end
        endcase
    end

    // Array is only usable in ACTIVE
    always_comb begin
        ram_ready = (state == ST_ACTIVE);
    end

    // Data flops carry no reset; the valid bits decide what a read may see
    always_ff @(posedge nvdla_core_clk) begin
        if (we_acc && wa_ok) mem[wa] <= wd;
    end

    // Valid bits: lost on reset or on a non-retaining sleep, set by writes
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            valid <= '0;
        end else if (sleep_entry && !ret_en) begin
            valid <= '0;
        end else if (we_acc && wa_ok) begin
            valid[wa] <= 1'b1;
        end
    end

    // Read data selection: out-of-range or invalid entries read as zero
    always_comb begin
        rd_data_nxt = '0;
        if (ra_ok) begin
            if ((BYPASS != 0) && we_acc && wa_ok && (wa == ra)) begin
                rd_data_nxt = wd;
            end else if (valid[ra]) begin
                rd_data_nxt = mem[ra];
            end
        end
    end

    // First read stage; data only moves on an accepted read so rd holds otherwise
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_vld <= re_acc;
            if (re_acc) s1_data <= rd_data_nxt;
        end
    end

    // Sticky flag for any access attempted while the array is not ready
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            err_drop <= 1'b0;
        end else if ((re || we) && !ram_ready) begin
            err_drop <= 1'b1;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s2_vld;
            logic [DW-1:0] s2_data;

            // Optional output register stage, also holding between valid reads
            always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
                if (!nvdla_core_rstn) begin
                    s2_vld  <= 1'b0;
                    s2_data <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) s2_data <= s1_data;
                end
            end

            assign rd_vld = s2_vld;
            assign rd     = s2_data;
        end else begin : g_lat1
            assign rd_vld = s1_vld;
            assign rd     = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_nv_ramdp_flop_param.sv
// Testbench for nv_ramdp_flop_param: a default instance (32 deep, latency 1,
// bypass) and a variant (20 deep, latency 2, no bypass) share one stimulus.
module tb_nv_ramdp_flop_param;

    logic        clk;
    logic        rstn;
    logic        re;
    logic [4:0]  ra;
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic        sleep_en;
    logic        ret_en;

    logic        rd_vld_a, ram_ready_a, err_drop_a;
    logic [15:0] rd_a;
    logic        rd_vld_b, ram_ready_b, err_drop_b;
    logic [15:0] rd_b;

    int test_count;
    int fail_count;

    nv_ramdp_flop_param u_dut_a (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .re              (re),
        .ra              (ra),
        .we              (we),
        .wa              (wa),
        .wd              (wd),
        .rd_vld          (rd_vld_a),
        .rd              (rd_a),
        .sleep_en        (sleep_en),
        .ret_en          (ret_en),
        .ram_ready       (ram_ready_a),
        .err_drop        (err_drop_a)
    );

    nv_ramdp_flop_param #(
        .DW(16), .DEPTH(20), .AW(5), .RD_LAT(2), .BYPASS(0), .WAKE_CYC(4)
    ) u_dut_b (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .re              (re),
        .ra              (ra),
        .we              (we),
        .wa              (wa),
        .wd              (wd),
        .rd_vld          (rd_vld_b),
        .rd              (rd_b),
        .sleep_en        (sleep_en),
        .ret_en          (ret_en),
        .ram_ready       (ram_ready_b),
        .err_drop        (err_drop_b)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [4:0] addr, input logic [15:0] data);
        we = 1'b1;
        wa = addr;
        wd = data;
        tick();
        we = 1'b0;
    endtask

    task automatic read_check(input logic [4:0] addr, input logic [15:0] exp_a, input logic [15:0] exp_b);
        re = 1'b1;
        ra = addr;
        tick();
        re = 1'b0;
        checkOutput("a_rd_vld", 32'(rd_vld_a), 32'd1);
        checkOutput("a_rd", 32'(rd_a), 32'(exp_a));
        checkOutput("b_rd_vld_early", 32'(rd_vld_b), 32'd0);
        tick();
        checkOutput("b_rd_vld", 32'(rd_vld_b), 32'd1);
        checkOutput("b_rd", 32'(rd_b), 32'(exp_b));
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20 && !(ram_ready_a && ram_ready_b); k++) tick();
        checkOutput("a_wake_ready", 32'(ram_ready_a), 32'd1);
        checkOutput("b_wake_ready", 32'(ram_ready_b), 32'd1);
    endtask

    task automatic sleep_cycle(input logic ret);
        sleep_en = 1'b1;
        ret_en   = ret;
        tick();
        ret_en   = 1'b0;
        tick();
        tick();
        checkOutput("sleep_not_ready", 32'(ram_ready_a), 32'd0);
        sleep_en = 1'b0;
        wait_ready();
    endtask

    function automatic logic [15:0] fill_pattern(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b};
    endfunction

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        int cnt_a;
        int cnt_b;
        test_count = 0;
        fail_count = 0;
        rstn = 1'b0; re = 1'b0; ra = '0; we = 1'b0; wa = '0; wd = '0;
        sleep_en = 1'b0; ret_en = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_rd_vld", 32'(rd_vld_a), 32'd0);
        checkOutput("rst_rd", 32'(rd_a), 32'd0);
        checkOutput("rst_ready", 32'(ram_ready_a), 32'd0);
        checkOutput("rst_err", 32'(err_drop_a), 32'd0);

        // Wake after reset takes exactly four edges
        @(negedge clk);
        rstn = 1'b1;
        tick(); tick(); tick();
        checkOutput("wake3_ready", 32'(ram_ready_a), 32'd0);
        tick();
        checkOutput("wake4_ready_a", 32'(ram_ready_a), 32'd1);
        checkOutput("wake4_ready_b", 32'(ram_ready_b), 32'd1);

        // Unwritten entry reads zero
        read_check(5'd7, 16'h0000, 16'h0000);

        // Write then read
        write_word(5'd3, 16'hA5A5);
        read_check(5'd3, 16'hA5A5, 16'hA5A5);

        // Back-to-back reads, one per cycle
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 34; i++) begin
            re = (i < 32);
            ra = 5'(i);
            tick();
            if (rd_vld_a) cnt_a++;
            if (rd_vld_b) cnt_b++;
        end
        re = 1'b0;
        checkOutput("b2b_count_a", 32'(cnt_a), 32'd32);
        checkOutput("b2b_count_b", 32'(cnt_b), 32'd32);

        // Same-cycle write/read to one address
        write_word(5'd9, 16'hBEEF);
        we = 1'b1; wa = 5'd9; wd = 16'h1234;
        re = 1'b1; ra = 5'd9;
        tick();
        we = 1'b0; re = 1'b0;
        checkOutput("bypass_a", 32'(rd_a), 32'h1234);
        tick();
        checkOutput("nobypass_b", 32'(rd_b), 32'hBEEF);
        read_check(5'd9, 16'h1234, 16'h1234);

        // Fill, sleep with retention, verify
        for (int i = 0; i < 32; i++) write_word(5'(i), fill_pattern(i));
        sleep_cycle(1'b1);
        for (int i = 0; i < 32; i++)
            read_check(5'(i), fill_pattern(i), (i < 20) ? fill_pattern(i) : 16'h0000);
        checkOutput("ret_err_a", 32'(err_drop_a), 32'd0);

        // Sleep without retention loses everything
        sleep_cycle(1'b0);
        for (int i = 0; i < 32; i++) read_check(5'(i), 16'h0000, 16'h0000);

        // Out-of-range address on the 20-deep instance
        write_word(5'd25, 16'h5555);
        read_check(5'd25, 16'h5555, 16'h0000);
        checkOutput("oor_err_b", 32'(err_drop_b), 32'd0);

        // Read on the ACTIVE->SLEEP edge, then dropped reads in SLEEP and WAKE
        write_word(5'd5, 16'h7777);
        sleep_en = 1'b1; ret_en = 1'b1;
        re = 1'b1; ra = 5'd5;
        tick();
        re = 1'b0; ret_en = 1'b0;
        checkOutput("edge_rd_vld_a", 32'(rd_vld_a), 32'd1);
        checkOutput("edge_rd_a", 32'(rd_a), 32'h7777);
        checkOutput("edge_ready", 32'(ram_ready_a), 32'd0);
        tick();
        checkOutput("edge_rd_vld_b", 32'(rd_vld_b), 32'd1);
        checkOutput("edge_rd_b", 32'(rd_b), 32'h7777);
        checkOutput("edge_err_a", 32'(err_drop_a), 32'd0);
        re = 1'b1;
        tick();
        re = 1'b0;
        checkOutput("sleep_drop_err", 32'(err_drop_a), 32'd1);
        checkOutput("sleep_drop_vld_a", 32'(rd_vld_a), 32'd0);
        tick();
        checkOutput("sleep_drop_vld_b", 32'(rd_vld_b), 32'd0);
        sleep_en = 1'b0;
        tick();
        re = 1'b1;
        tick();
        re = 1'b0;
        checkOutput("wake_drop_vld_a", 32'(rd_vld_a), 32'd0);
        checkOutput("wake_drop_ready", 32'(ram_ready_a), 32'd0);
        wait_ready();
        checkOutput("sticky_err_a", 32'(err_drop_a), 32'd1);
        checkOutput("sticky_err_b", 32'(err_drop_b), 32'd1);
        read_check(5'd5, 16'h7777, 16'h7777);

        // Reset with a read in flight
        re = 1'b1; ra = 5'd5;
        tick();
        re = 1'b0;
        checkOutput("inflight_vld_a", 32'(rd_vld_a), 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("rst_flight_vld_a", 32'(rd_vld_a), 32'd0);
        checkOutput("rst_flight_vld_b", 32'(rd_vld_b), 32'd0);
        checkOutput("rst_flight_rd_b", 32'(rd_b), 32'd0);
        checkOutput("rst_flight_err", 32'(err_drop_a), 32'd0);
        checkOutput("rst_flight_ready", 32'(ram_ready_a), 32'd0);
        tick();
        checkOutput("rst_hold_vld_b", 32'(rd_vld_b), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();
        checkOutput("post_rst_vld_a", 32'(rd_vld_a), 32'd0);
        checkOutput("post_rst_vld_b", 32'(rd_vld_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
